// File: rtl/xalu.sv
// Multiply/divide unit for the E stage: holds HI/LO and runs mult/div over a
// fixed latency. Results are computed at acceptance and committed on expiry.
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] out
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [31:0] hi_reg, lo_reg;
    logic [31:0] p_hi_reg, p_lo_reg;
    logic [3:0]  cnt_reg;

    logic        idle;
    logic        is_muldiv;
    logic        is_mult;
    logic        accept;

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag, quo, rem;
    logic [31:0] res_hi_next, res_lo_next;

    assign idle      = (cnt_reg == 4'd0);
    assign is_mult   = (op == OP_MULT) || (op == OP_MULTU);
    assign is_muldiv = is_mult || (op == OP_DIV) || (op == OP_DIVU);
    assign accept    = start && idle && is_muldiv;

    // Low 64 bits of the product of sign-extended operands give the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division through magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without special handling.
    assign a_neg  = (op == OP_DIV) && a[31];
    assign b_neg  = (op == OP_DIV) && b[31];
    assign a_mag  = a_neg ? (32'd0 - a) : a;
    assign b_mag  = b_neg ? (32'd0 - b) : b;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_hi_next = hi_reg;
        res_lo_next = lo_reg;
        case (op)
            OP_MULT:  {res_hi_next, res_lo_next} = prod_s;
            OP_MULTU: {res_hi_next, res_lo_next} = prod_u;
            OP_DIV, OP_DIVU: begin
                // HI/LO cannot change while busy, so a divide by zero simply
                // recommits their current values.
                if (b != 32'd0) begin
                    res_hi_next = rem;
                    res_lo_next = quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            p_hi_reg <= 32'd0;
            p_lo_reg <= 32'd0;
            cnt_reg  <= 4'd0;
        end else if (idle) begin
            if (accept) begin
                p_hi_reg <= res_hi_next;
                p_lo_reg <= res_lo_next;
                cnt_reg  <= is_mult ? MULT_LOAD : DIV_LOAD;
            end else if (start && op == OP_MTHI) begin
                hi_reg <= a;
            end else if (start && op == OP_MTLO) begin
                lo_reg <= a;
            end
        end else begin
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
                hi_reg <= p_hi_reg;
                lo_reg <= p_lo_reg;
            end
        end
    end

    assign busy = reset && (accept || !idle);
    assign out  = rd_sel ? hi_reg : lo_reg;

endmodule
